// File: rtl/simple_proc_pkg.sv
// Shared opcode map, execute-function encoding and instruction-width derivation for the ALU pipe.
package simple_proc_pkg;

    localparam logic [7:0] OPC_ADD     = 8'h88;
    localparam logic [7:0] OPC_SUB     = 8'h89;
    localparam logic [7:0] OPC_INC     = 8'h8A;
    localparam logic [7:0] OPC_DEC     = 8'h8B;
    localparam logic [7:0] OPC_AND     = 8'h8C;
    localparam logic [7:0] OPC_OR      = 8'h8D;
    localparam logic [7:0] OPC_XOR     = 8'h8E;
    localparam logic [7:0] OPC_ACC_ADD = 8'h90;
    localparam logic [7:0] OPC_ACC_CLR = 8'h91;

    typedef enum logic [3:0] {
        FN_ADD,
        FN_SUB,
        FN_INC,
        FN_DEC,
        FN_AND,
        FN_OR,
        FN_XOR,
        FN_ACC_ADD,
        FN_ACC_CLR,
        FN_ILLEGAL
    } func_t;

    function automatic int instr_width(input int data_w);
        return 8 + 2 * data_w;
    endfunction

    function automatic func_t decode_opcode(input logic [7:0] opc);
        func_t fn;
        case (opc)
            OPC_ADD:     fn = FN_ADD;
            OPC_SUB:     fn = FN_SUB;
            OPC_INC:     fn = FN_INC;
            OPC_DEC:     fn = FN_DEC;
            OPC_AND:     fn = FN_AND;
            OPC_OR:      fn = FN_OR;
            OPC_XOR:     fn = FN_XOR;
            OPC_ACC_ADD: fn = FN_ACC_ADD;
            OPC_ACC_CLR: fn = FN_ACC_CLR;
            default:     fn = FN_ILLEGAL;
        endcase
        return fn;
    endfunction

endpackage

// File: rtl/simple_alu_exec.sv
// Combinational execute: one DATA_W+1 bit datapath; the top bit is carry for adds, borrow for subtracts.
// No latency, no handshake; the caller decides when result and acc_next are committed.
module simple_alu_exec
    import simple_proc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  func_t              func,
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    input  logic [DATA_W-1:0]  acc,
    output logic [DATA_W-1:0]  result,
    output logic               carry,
    output logic [DATA_W-1:0]  acc_next,
    output logic               illegal
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide     = '0;
        acc_next = acc;
        illegal  = 1'b0;
        case (func)
            FN_ADD:     wide = {1'b0, a} + {1'b0, b};
            FN_SUB:     wide = {1'b0, a} - {1'b0, b};
            FN_INC:     wide = {1'b0, a} + (DATA_W+1)'(1);
            FN_DEC:     wide = {1'b0, a} - (DATA_W+1)'(1);
            FN_AND:     wide = {1'b0, a & b};
            FN_OR:      wide = {1'b0, a | b};
            FN_XOR:     wide = {1'b0, a ^ b};
            FN_ACC_ADD: begin
                wide     = {1'b0, acc} + {1'b0, a};
                acc_next = wide[DATA_W-1:0];
            end
            FN_ACC_CLR: acc_next = '0;
            // Illegal ops leave wide at zero, so result=0 and carry=0 fall out naturally.
            default:    illegal = 1'b1;
        endcase
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
    end

endmodule

// File: rtl/simple_alu_pipe.sv
// Two-stage decode/execute ALU with accumulator and saturating handoff counter; result 2 edges after acceptance, 1 op/clk.
// Backpressure: a stalled output holds out_*/acc_value; in_ready drops once stage 1 is also full.
module simple_alu_pipe
    import simple_proc_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int COUNT_W = 16,
    localparam int INSTR_W = instr_width(DATA_W)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_result,
    output logic                out_carry,
    output logic                out_zero,
    output logic                out_illegal,
    output logic [DATA_W-1:0]   acc_value,
    output logic [COUNT_W-1:0]  op_count
);

    logic               s1_valid;
    func_t              s1_func;
    logic [DATA_W-1:0]  s1_a;
    logic [DATA_W-1:0]  s1_b;
    logic               s2_adv;

    logic [DATA_W-1:0]  ex_result;
    logic               ex_carry;
    logic [DATA_W-1:0]  ex_acc_next;
    logic               ex_illegal;

    assign s2_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_func  <= FN_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_func <= decode_opcode(in_instr[INSTR_W-1 -: 8]);
                s1_a    <= in_instr[DATA_W-1:0];
                s1_b    <= in_instr[2*DATA_W-1:DATA_W];
            end
        end
    end

    simple_alu_exec #(
        .DATA_W (DATA_W)
    ) u_exec (
        .func     (s1_func),
        .a        (s1_a),
        .b        (s1_b),
        .acc      (acc_value),
        .result   (ex_result),
        .carry    (ex_carry),
        .acc_next (ex_acc_next),
        .illegal  (ex_illegal)
    );

    // The accumulator commits together with stage 2, so chained ACC ops see each other in order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_carry   <= 1'b0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
            acc_value   <= '0;
        end else if (s2_adv) begin
            out_valid   <= 1'b1;
            out_result  <= ex_result;
            out_carry   <= ex_carry;
            out_zero    <= (ex_result == '0);
            out_illegal <= ex_illegal;
            acc_value   <= ex_acc_next;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (out_valid && out_ready && (op_count != {COUNT_W{1'b1}})) begin
            op_count <= op_count + COUNT_W'(1);
        end
    end

endmodule
